// File: rtl/kbd_num_queue_if.sv
// rtl/kbd_num_queue_if.sv - keyboard number queue handshake bundle
// Signals:
//   code[15:0]  PS/2 byte history, [15:8] previous byte, [7:0] newest byte
//   code_stb    one-cycle pulse, new byte valid on code
//   clr         synchronous flush
//   control     CPU ready to take the head value
//   status      head value valid (queue not empty)
//   num         head value, 0 when empty
//   count       current occupancy
//   overflow    sticky, a key was dropped on a full queue
// master drives the byte stream and CPU controls, slave is the queue.
interface kbd_num_queue_if #(
   parameter int DEPTH     = 8,
   parameter int NUM_WIDTH = 4
);
   logic [15:0]              code;
   logic                     code_stb;
   logic                     clr;
   logic                     control;
   logic                     status;
   logic [NUM_WIDTH-1:0]     num;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;

   modport master (
      output code, code_stb, clr, control,
      input  status, num, count, overflow
   );

   modport slave (
      input  code, code_stb, clr, control,
      output status, num, count, overflow
   );
endinterface

// File: rtl/kbd_num_queue.sv
// rtl/kbd_num_queue.sv - PS/2 make-code to number FIFO with backspace and CPU handshake
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   asynchronous active-high reset
//   bus   kbd_num_queue_if slave: code/code_stb in, clr, control in,
//         status/num/count/overflow out
// Parameters: DEPTH (power of two, >= 2), NUM_WIDTH (>= 4), HEX_EN (accept A-F).
module kbd_num_queue #(
   parameter int DEPTH     = 8,
   parameter int NUM_WIDTH = 4,
   parameter int HEX_EN    = 0
) (
   input logic             clk,
   input logic             rst,
   kbd_num_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [NUM_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count_q;
   logic                 ovf_q;
   logic [7:0]           held;

   logic [7:0]           key;
   logic                 is_prefix;
   logic                 is_break;
   logic                 is_new_make;
   logic                 dig_ok;
   logic [3:0]           dig_val;
   logic                 push_req;
   logic                 bs_req;
   logic                 status_i;
   logic                 full;
   logic                 pop;
   logic                 push_ok;
   logic                 drop;
   logic                 bs_ok;

   assign status_i = (count_q != '0);
   assign full     = (count_q == CW'(DEPTH));

   always_comb begin
      key         = bus.code[7:0];
      is_prefix   = (key == 8'hF0) || (key == 8'hE0);
      is_break    = !is_prefix && (bus.code[15:8] == 8'hF0);
      // A make equal to the held key is typematic repeat and is dropped.
      is_new_make = bus.code_stb && !is_prefix && !is_break && (key != held);

      dig_ok  = 1'b1;
      dig_val = 4'h0;
      case (key)
         8'h45: dig_val = 4'h0;
         8'h16: dig_val = 4'h1;
         8'h1E: dig_val = 4'h2;
         8'h26: dig_val = 4'h3;
         8'h25: dig_val = 4'h4;
         8'h2E: dig_val = 4'h5;
         8'h36: dig_val = 4'h6;
         8'h3D: dig_val = 4'h7;
         8'h3E: dig_val = 4'h8;
         8'h46: dig_val = 4'h9;
         8'h1C: begin dig_val = 4'hA; dig_ok = (HEX_EN != 0); end
         8'h32: begin dig_val = 4'hB; dig_ok = (HEX_EN != 0); end
         8'h21: begin dig_val = 4'hC; dig_ok = (HEX_EN != 0); end
         8'h23: begin dig_val = 4'hD; dig_ok = (HEX_EN != 0); end
         8'h24: begin dig_val = 4'hE; dig_ok = (HEX_EN != 0); end
         8'h2B: begin dig_val = 4'hF; dig_ok = (HEX_EN != 0); end
         default: dig_ok = 1'b0;
      endcase

      push_req = is_new_make && dig_ok;
      bs_req   = is_new_make && (key == 8'h66);
      pop      = status_i && bus.control;
      // A same-cycle pop frees the slot, so a full queue still accepts.
      push_ok  = push_req && (!full || pop);
      drop     = push_req && full && !pop;
      // With a pop in flight the last entry is already leaving, so a
      // backspace needs a second entry to remove.
      bs_ok    = bs_req && (pop ? (count_q > CW'(1)) : status_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         held    <= 8'h00;
      end else if (bus.clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         held    <= 8'h00;
      end else begin
         if (bus.code_stb && is_break && (key == held))
            held <= 8'h00;
         else if (is_new_make)
            held <= key;

         // Push and backspace come from the same byte, so they never coincide.
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         else if (bs_ok)
            wr_ptr <= wr_ptr - PW'(1);

         if (pop)
            rd_ptr <= rd_ptr + PW'(1);

         count_q <= count_q + CW'(push_ok) - CW'(pop) - CW'(bs_ok);

         if (drop)
            ovf_q <= 1'b1;
      end
   end

   // Storage needs no reset: num is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= NUM_WIDTH'(dig_val);
   end

   assign bus.status   = status_i;
   assign bus.num      = status_i ? mem[rd_ptr] : '0;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_kbd_num_queue.sv
// tb/tb_kbd_num_queue.sv - directed scoreboard bench for kbd_num_queue
module tb_kbd_num_queue;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   kbd_num_queue_if #(.DEPTH(DEPTH), .NUM_WIDTH(4)) bus ();
   kbd_num_queue_if #(.DEPTH(DEPTH), .NUM_WIDTH(6)) hbus ();

   kbd_num_queue #(.DEPTH(DEPTH), .NUM_WIDTH(4), .HEX_EN(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   kbd_num_queue #(.DEPTH(DEPTH), .NUM_WIDTH(6), .HEX_EN(1)) dut_hex (
      .clk (clk),
      .rst (rst),
      .bus (hbus)
   );

   int         checks = 0;
   int         passed = 0;
   logic [3:0] mq [$];
   logic [7:0] m_held = 8'h00;
   logic       m_ovf  = 1'b0;
   logic [7:0] prev_b = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit ref_decode(input logic [7:0] k, input bit hex, output logic [3:0] v);
      v = 4'h0;
      case (k)
         8'h45: begin v = 4'd0; return 1'b1; end
         8'h16: begin v = 4'd1; return 1'b1; end
         8'h1E: begin v = 4'd2; return 1'b1; end
         8'h26: begin v = 4'd3; return 1'b1; end
         8'h25: begin v = 4'd4; return 1'b1; end
         8'h2E: begin v = 4'd5; return 1'b1; end
         8'h36: begin v = 4'd6; return 1'b1; end
         8'h3D: begin v = 4'd7; return 1'b1; end
         8'h3E: begin v = 4'd8; return 1'b1; end
         8'h46: begin v = 4'd9; return 1'b1; end
         8'h1C: begin v = 4'd10; return hex; end
         8'h32: begin v = 4'd11; return hex; end
         8'h21: begin v = 4'd12; return hex; end
         8'h23: begin v = 4'd13; return hex; end
         8'h24: begin v = 4'd14; return hex; end
         8'h2B: begin v = 4'd15; return hex; end
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_state(input string tag);
      chk({tag, ".count"},    32'(bus.count),    mq.size());
      chk({tag, ".status"},   32'(bus.status),   32'(mq.size() != 0));
      chk({tag, ".num"},      32'(bus.num),      (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
   endtask

   task automatic step(input string tag, input bit stb, input logic [7:0] b, input bit ctl);
      logic [3:0] v;
      logic [3:0] tmp;
      bus.code     = {prev_b, b};
      bus.code_stb = stb;
      bus.control  = ctl;
      if (ctl && mq.size() != 0) begin
         chk({tag, ".pop_value"}, 32'(bus.num), 32'(mq[0]));
         tmp = mq.pop_front();
      end
      if (stb) begin
         if (b == 8'hF0 || b == 8'hE0) begin
         end else if (prev_b == 8'hF0) begin
            if (b == m_held) m_held = 8'h00;
         end else if (b != m_held) begin
            m_held = b;
            if (b == 8'h66) begin
               if (mq.size() != 0) tmp = mq.pop_back();
            end else if (ref_decode(b, 1'b0, v)) begin
               if (mq.size() < DEPTH) mq.push_back(v);
               else m_ovf = 1'b1;
            end
         end
         prev_b = b;
      end
      @(posedge clk);
      #1;
      bus.code_stb = 1'b0;
      bus.control  = 1'b0;
      check_state(tag);
   endtask

   task automatic press(input string tag, input logic [7:0] k);
      step(tag, 1'b1, k, 1'b0);
      step(tag, 1'b1, 8'hF0, 1'b0);
      step(tag, 1'b1, k, 1'b0);
   endtask

   task automatic pop_one(input string tag);
      step(tag, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic do_clr(input string tag, input logic [7:0] b);
      bus.clr      = 1'b1;
      bus.code     = {prev_b, b};
      bus.code_stb = 1'b1;
      prev_b       = b;
      mq.delete();
      m_ovf  = 1'b0;
      m_held = 8'h00;
      @(posedge clk);
      #1;
      bus.clr      = 1'b0;
      bus.code_stb = 1'b0;
      check_state(tag);
   endtask

   initial begin
      bus.code = '0; bus.code_stb = 1'b0; bus.clr = 1'b0; bus.control = 1'b0;
      hbus.code = '0; hbus.code_stb = 1'b0; hbus.clr = 1'b0; hbus.control = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single key with break sequence
      step("k1_make", 1'b1, 8'h16, 1'b0);
      step("k1_f0",   1'b1, 8'hF0, 1'b0);
      step("k1_brk",  1'b1, 8'h16, 1'b0);
      pop_one("k1_pop");

      // auto-repeat suppression
      step("rep1", 1'b1, 8'h1E, 1'b0);
      step("rep2", 1'b1, 8'h1E, 1'b0);
      step("rep3", 1'b1, 8'h1E, 1'b0);
      step("rep_f0",  1'b1, 8'hF0, 1'b0);
      step("rep_brk", 1'b1, 8'h1E, 1'b0);
      pop_one("rep_pop");

      // fill, overflow, drain in order, clear
      press("fill1", 8'h16); press("fill2", 8'h1E); press("fill3", 8'h26);
      press("fill4", 8'h25); press("fill5", 8'h2E); press("fill6", 8'h36);
      press("fill7", 8'h3D); press("fill8", 8'h3E);
      press("over9", 8'h46);
      for (int i = 0; i < DEPTH; i++) pop_one("drain");
      do_clr("clr_ovf", 8'h00);

      // backspace editing
      press("bs_p3", 8'h26);
      press("bs_p7", 8'h3D);
      press("bs_1",  8'h66);
      press("bs_2",  8'h66);
      press("bs_empty", 8'h66);

      // hex key ignored when HEX_EN=0, decoded to 10 when HEX_EN=1
      press("hex_off", 8'h1C);
      hbus.code = {8'h00, 8'h1C};
      hbus.code_stb = 1'b1;
      @(posedge clk);
      #1;
      hbus.code_stb = 1'b0;
      chk("hex_on.num",   32'(hbus.num),   32'd10);
      chk("hex_on.count", 32'(hbus.count), 32'd1);

      // full queue: push and pop in the same cycle
      press("f1", 8'h16); press("f2", 8'h1E); press("f3", 8'h26); press("f4", 8'h25);
      press("f5", 8'h2E); press("f6", 8'h36); press("f7", 8'h3D); press("f8", 8'h3E);
      step("full_pushpop", 1'b1, 8'h2E, 1'b1);
      step("full_rel_f0",  1'b1, 8'hF0, 1'b0);
      step("full_rel",     1'b1, 8'h2E, 1'b0);
      for (int i = 0; i < DEPTH; i++) pop_one("full_drain");

      // backspace together with a pop
      press("bp_a", 8'h45);
      press("bp_b", 8'h46);
      step("bp_cnt2", 1'b1, 8'h66, 1'b1);
      step("bp_f0",   1'b1, 8'hF0, 1'b0);
      step("bp_rel",  1'b1, 8'h66, 1'b0);
      press("bp_c", 8'h36);
      step("bp_cnt1", 1'b1, 8'h66, 1'b1);
      step("bp_f0b",  1'b1, 8'hF0, 1'b0);
      step("bp_relb", 1'b1, 8'h66, 1'b0);

      // clr wins over a same-cycle strobe and clears overflow
      for (int i = 0; i < DEPTH; i++) press("cf", (i % 2 == 0) ? 8'h16 : 8'h1E);
      press("cf_ovf", 8'h26);
      do_clr("clr_prio", 8'h25);
      step("clr_after", 1'b1, 8'h25, 1'b0);

      // asynchronous reset mid-operation with a pending handshake
      press("ar_a", 8'h36);
      bus.control = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst.status", 32'(bus.status), 32'd0);
      chk("async_rst.count",  32'(bus.count),  32'd0);
      mq.delete();
      m_ovf  = 1'b0;
      m_held = 8'h00;
      @(posedge clk);
      #1;
      bus.control = 1'b0;
      rst = 1'b0;
      check_state("after_rst");
      press("post_rst", 8'h36);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
